// File: rtl/rotator_arbiter.sv
// rotator_arbiter: round-robin front end sharing one N-bit rotate-right unit among R requesters.
// Optional feature macro ROTATE_LEFT_EN adds per-requester reqDir (1 = rotate left).
module rotator_arbiter #(
   parameter int unsigned N = 8,
   parameter int unsigned R = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [R-1:0]           reqValid,
   input  logic [R*N-1:0]         reqData,
   input  logic [R*$clog2(N)-1:0] reqAmount,
`ifdef ROTATE_LEFT_EN
   input  logic [R-1:0]           reqDir,
`endif
   output logic [R-1:0]           reqReady,
   output logic                   rspValid,
   output logic [N-1:0]           rspData,
   output logic [$clog2(R)-1:0]   rspId,
   input  logic                   rspReady,
   output logic                   busy
);

   localparam int unsigned A = $clog2(N);
   localparam int unsigned I = $clog2(R);

   typedef enum logic [1:0] {StIdle, StRotate, StResp} state_e;

   state_e         state_q;
   logic [I-1:0]   ptr_q;
   logic [N-1:0]   op_q;
   logic [A-1:0]   amt_q;
   logic [I-1:0]   id_q;
   logic           rsp_valid_q;
   logic [N-1:0]   rsp_data_q;
   logic [I-1:0]   rsp_id_q;

   logic           grant_found;
   logic [I-1:0]   grant_idx;
   logic [N-1:0]   sel_data;
   logic [A-1:0]   sel_amt_raw;
   logic [A-1:0]   sel_amt;
   logic [N-1:0]   rot_res;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int unsigned i = 1; i <= R; i++) begin
         if (!grant_found && reqValid[(32'(ptr_q) + i) % R]) begin
            grant_found = 1'b1;
            grant_idx   = I'((32'(ptr_q) + i) % R);
         end
      end
   end

   always_comb begin
      sel_data    = reqData[32'(grant_idx)*N +: N];
      sel_amt_raw = reqAmount[32'(grant_idx)*A +: A];
      sel_amt     = sel_amt_raw;
`ifdef ROTATE_LEFT_EN
      // Left by k equals right by (N - k) mod N; N is a power of two so negate in A bits.
      if (reqDir[grant_idx]) begin
         sel_amt = A'(0) - sel_amt_raw;
      end
`endif
   end

   always_comb begin
      reqReady = '0;
      if (state_q == StIdle && !reset && grant_found) begin
         reqReady[grant_idx] = 1'b1;
      end
   end

   assign rot_res = N'({op_q, op_q} >> amt_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         ptr_q       <= I'(R - 1);
         op_q        <= '0;
         amt_q       <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_found) begin
                  op_q    <= sel_data;
                  amt_q   <= sel_amt;
                  id_q    <= grant_idx;
                  ptr_q   <= grant_idx;
                  state_q <= StRotate;
               end
            end
            StRotate: begin
               rsp_data_q  <= rot_res;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= StResp;
            end
            StResp: begin
               if (rspReady) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rspValid = rsp_valid_q;
   assign rspData  = rsp_data_q;
   assign rspId    = rsp_id_q;
   assign busy     = (state_q != StIdle);

endmodule
